// File: rtl/modarith_pkg.sv
// Shared constants for the modular add/sub scheduler: op encoding and supported datapath latency.
package modarith_pkg;
  localparam logic OP_ADD      = 1'b0;
  localparam logic OP_SUB      = 1'b1;
  localparam int   MAX_LATENCY = 2;
endpackage

// File: rtl/modarith_rr_scheduler_if.sv
// Requester-facing bundle of the scheduler: per-requester issue handshake plus the tagged response stream.
interface modarith_rr_scheduler_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  // Requester i's op transfers on a cycle where req_valid[i] && req_ready[i]; until then the
  // requester holds req_valid/req_op/req_a/req_b stable. Responses have no ready: rsp_valid is a
  // one-cycle pulse the consumer must take.
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       req_op;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic                     rsp_valid;
  logic [ID_W-1:0]          rsp_id;
  logic [WIDTH-1:0]         rsp_data;

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first request after the last winner, wrapping; the pointer
// moves to the winner only when the grant is actually taken (i_advance).
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_id
);
  localparam logic [ID_W:0] NR = (ID_W+1)'(NUM_REQ);

  logic [ID_W-1:0] r_ptr;
  logic [ID_W:0]   w_idx;
  logic            w_found;

  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    w_found    = 1'b0;
    w_idx      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_idx >= NR) w_idx = w_idx - NR;
      if (!w_found && i_req[w_idx[ID_W-1:0]]) begin
        w_found    = 1'b1;
        o_grant_id = w_idx[ID_W-1:0];
      end
    end
    if (w_found) o_grant[o_grant_id] = 1'b1;
  end

  // Reset value NUM_REQ-1 makes requester 0 the first in line.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_ptr <= ID_W'(NUM_REQ - 1);
    else if (i_advance) r_ptr <= o_grant_id;
  end
endmodule

// File: rtl/modarith_rr_scheduler.sv
// Shares one pipelined modular add/sub datapath among NUM_REQ requesters; a requester-ID tag pipe
// matched to the datapath latency labels each registered response.
module modarith_rr_scheduler
  import modarith_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 2,
  localparam int ID_W   = $clog2(NUM_REQ)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_hold,
  modarith_rr_scheduler_if.slave bus,
  output logic                   o_dp_valid,
  output logic                   o_dp_op,
  output logic [WIDTH-1:0]       o_dp_a,
  output logic [WIDTH-1:0]       o_dp_b,
  input  logic [WIDTH-1:0]       i_dp_result,
  output logic                   o_busy
);
  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_id;
  logic [NUM_REQ-1:0] w_ready;
  logic               w_fire;
  logic               w_tag_v;
  logic [ID_W-1:0]    w_tag_id;
  logic               w_pipe_busy;
  logic               r_rsp_valid;
  logic [ID_W-1:0]    r_rsp_id;
  logic [WIDTH-1:0]   r_rsp_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_req      (bus.req_valid),
    .i_advance  (w_fire),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id)
  );

  // Reset also masks the combinational accept path so nothing issues while reset is held.
  assign w_ready       = w_grant & {NUM_REQ{~i_hold & ~i_rst}};
  assign w_fire        = |(bus.req_valid & w_ready);
  assign bus.req_ready = w_ready;

  always_comb begin
    o_dp_valid = w_fire;
    o_dp_op    = OP_ADD;
    o_dp_a     = '0;
    o_dp_b     = '0;
    if (w_fire) begin
      o_dp_op = bus.req_op[w_grant_id];
      o_dp_a  = bus.req_a[w_grant_id*WIDTH +: WIDTH];
      o_dp_b  = bus.req_b[w_grant_id*WIDTH +: WIDTH];
    end
  end

  generate
    if (LATENCY == 0) begin : g_no_pipe
      assign w_tag_v     = w_fire;
      assign w_tag_id    = w_grant_id;
      assign w_pipe_busy = 1'b0;
    end else begin : g_pipe
      logic [LATENCY-1:0] r_tag_v;
      logic [ID_W-1:0]    r_tag_id [LATENCY];

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          r_tag_v <= '0;
          for (int s = 0; s < LATENCY; s++) r_tag_id[s] <= '0;
        end else begin
          r_tag_v[0]  <= w_fire;
          r_tag_id[0] <= w_grant_id;
          for (int s = 1; s < LATENCY; s++) begin
            r_tag_v[s]  <= r_tag_v[s-1];
            r_tag_id[s] <= r_tag_id[s-1];
          end
        end
      end

      assign w_tag_v     = r_tag_v[LATENCY-1];
      assign w_tag_id    = r_tag_id[LATENCY-1];
      assign w_pipe_busy = |r_tag_v;
    end
  endgenerate

  // The last tag stage lines up with the datapath output of the same op.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
    end else begin
      r_rsp_valid <= w_tag_v;
      if (w_tag_v) begin
        r_rsp_id   <= w_tag_id;
        r_rsp_data <= i_dp_result;
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_data  = r_rsp_data;
  assign o_busy        = w_pipe_busy | r_rsp_valid;
endmodule

// File: tb/tb_modarith_rr_scheduler.sv
// Bench: three schedulers (LATENCY 0,1,2) share one randomized requester stream, each driving its own
// modular add/sub datapath (MODULUS 12289); responses are scored against an arbitration/arithmetic model.
module tb_modarith_rr_scheduler;
  import modarith_pkg::*;

  localparam int WIDTH   = 16;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int MODULUS = 12289;
  localparam int NLAT    = MAX_LATENCY + 1;
  localparam int EW      = 32 + ID_W + WIDTH;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic                     hold = 1'b0;
  logic [NUM_REQ-1:0]       req_valid = '0;
  logic [NUM_REQ-1:0]       req_op = '0;
  logic [NUM_REQ*WIDTH-1:0] req_a = '0;
  logic [NUM_REQ*WIDTH-1:0] req_b = '0;

  logic [NUM_REQ-1:0] t_ready     [NLAT];
  logic               t_dp_valid  [NLAT];
  logic               t_dp_op     [NLAT];
  logic [WIDTH-1:0]   t_dp_a      [NLAT];
  logic [WIDTH-1:0]   t_dp_b      [NLAT];
  logic               t_rsp_valid [NLAT];
  logic [ID_W-1:0]    t_rsp_id    [NLAT];
  logic [WIDTH-1:0]   t_rsp_data  [NLAT];
  logic               t_busy      [NLAT];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // ---------------- clock / cycle count ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int lat, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s lat=%0d cycle=%0d actual=%0h expected=%0h", name, lat, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int               m_ptr;
  logic             m_fire;
  logic [ID_W-1:0]  m_id;
  logic [NUM_REQ-1:0] m_ready;
  logic             m_op;
  logic [WIDTH-1:0] m_a, m_b, m_val;

  always_comb begin
    m_fire  = 1'b0;
    m_id    = '0;
    m_ready = '0;
    m_op    = 1'b0;
    m_a     = '0;
    m_b     = '0;
    m_val   = '0;
    if (!rst && !hold)
      for (int j = 1; j <= NUM_REQ; j++)
        if (!m_fire && req_valid[(m_ptr + j) % NUM_REQ]) begin
          m_fire = 1'b1;
          m_id   = ID_W'((m_ptr + j) % NUM_REQ);
        end
    if (m_fire) begin
      m_ready[m_id] = 1'b1;
      m_op  = req_op[m_id];
      m_a   = req_a[m_id*WIDTH +: WIDTH];
      m_b   = req_b[m_id*WIDTH +: WIDTH];
      m_val = (m_op == OP_SUB) ? WIDTH'((int'(m_a) - int'(m_b) + MODULUS) % MODULUS)
                               : WIDTH'((int'(m_a) + int'(m_b)) % MODULUS);
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) m_ptr <= NUM_REQ - 1;
    else if (m_fire) m_ptr <= int'(m_id);
  end

  // ---------------- DUTs, datapaths, per-latency scoreboards ----------------
  for (genvar gk = 0; gk < NLAT; gk++) begin : g_lat
    modarith_rr_scheduler_if #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) bus ();
    logic [WIDTH-1:0] dp_result, dp_comb, dp_s1, dp_s2;
    logic [EW-1:0]    exp_q[$];

    assign bus.req_valid = req_valid;
    assign bus.req_op    = req_op;
    assign bus.req_a     = req_a;
    assign bus.req_b     = req_b;
    assign t_ready[gk]     = bus.req_ready;
    assign t_rsp_valid[gk] = bus.rsp_valid;
    assign t_rsp_id[gk]    = bus.rsp_id;
    assign t_rsp_data[gk]  = bus.rsp_data;

    modarith_rr_scheduler #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .LATENCY(gk)) u_dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_hold      (hold),
      .bus         (bus),
      .o_dp_valid  (t_dp_valid[gk]),
      .o_dp_op     (t_dp_op[gk]),
      .o_dp_a      (t_dp_a[gk]),
      .o_dp_b      (t_dp_b[gk]),
      .i_dp_result (dp_result),
      .o_busy      (t_busy[gk])
    );

    assign dp_comb = (t_dp_op[gk] == OP_SUB)
      ? ((t_dp_a[gk] >= t_dp_b[gk]) ? t_dp_a[gk] - t_dp_b[gk] : t_dp_a[gk] + WIDTH'(MODULUS) - t_dp_b[gk])
      : ((t_dp_a[gk] + t_dp_b[gk] >= WIDTH'(MODULUS)) ? t_dp_a[gk] + t_dp_b[gk] - WIDTH'(MODULUS)
                                                      : t_dp_a[gk] + t_dp_b[gk]);
    always @(posedge clk) begin
      dp_s1 <= dp_comb;
      dp_s2 <= dp_s1;
    end
    assign dp_result = (gk == 0) ? dp_comb : (gk == 1) ? dp_s1 : dp_s2;

    always @(negedge clk) begin : mon
      logic [EW-1:0] e;
      logic          exp_busy;
      if (rst) exp_q.delete();
      else begin
        exp_busy = (exp_q.size() != 0);
        check("busy", gk, 32'(t_busy[gk]), 32'(exp_busy));
        if (m_fire) exp_q.push_back({32'(cyc + gk + 1), m_id, m_val});
        if (t_rsp_valid[gk]) begin
          if (exp_q.size() == 0) check("rsp_unexpected", gk, 32'(t_rsp_valid[gk]), 32'(0));
          else begin
            e = exp_q.pop_front();
            check("rsp_cycle", gk, 32'(cyc), e[EW-1 -: 32]);
            check("rsp_id", gk, 32'(t_rsp_id[gk]), 32'(e[WIDTH +: ID_W]));
            check("rsp_data", gk, 32'(t_rsp_data[gk]), 32'(e[WIDTH-1:0]));
          end
        end else if (exp_q.size() != 0 && int'(exp_q[0][EW-1 -: 32]) <= cyc) begin
          e = exp_q.pop_front();
          check("rsp_missing", gk, 32'(t_rsp_valid[gk]), 32'(1));
        end
      end
    end
  end

  // ---------------- per-cycle issue-side checks ----------------
  always @(negedge clk) begin
    for (int k = 0; k < NLAT; k++) begin
      if (rst) begin
        check("rst_ready", k, 32'(t_ready[k]), 32'(0));
        check("rst_dp_valid", k, 32'(t_dp_valid[k]), 32'(0));
        check("rst_dp_a", k, 32'(t_dp_a[k]), 32'(0));
        check("rst_rsp_valid", k, 32'(t_rsp_valid[k]), 32'(0));
        check("rst_rsp_id", k, 32'(t_rsp_id[k]), 32'(0));
        check("rst_rsp_data", k, 32'(t_rsp_data[k]), 32'(0));
        check("rst_busy", k, 32'(t_busy[k]), 32'(0));
      end else begin
        check("ready", k, 32'(t_ready[k]), 32'(m_ready));
        check("dp_valid", k, 32'(t_dp_valid[k]), 32'(m_fire));
        check("dp_op", k, 32'(t_dp_op[k]), 32'(m_op));
        check("dp_a", k, 32'(t_dp_a[k]), 32'(m_a));
        check("dp_b", k, 32'(t_dp_b[k]), 32'(m_b));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int i, input logic v, input logic op, input int a, input int b);
    req_valid[i] = v;
    req_op[i]    = op;
    req_a[i*WIDTH +: WIDTH] = WIDTH'(a);
    req_b[i*WIDTH +: WIDTH] = WIDTH'(b);
  endtask

  function automatic int rand_operand();
    if ($urandom_range(0, 7) == 0) return MODULUS - 1;
    return int'($urandom_range(0, MODULUS - 1));
  endfunction

  task automatic rand_req(input int i);
    set_req(i, 1'b1, 1'($urandom_range(0, 1)), rand_operand(), rand_operand());
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) next_cycle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic            f;
    logic [ID_W-1:0] fid;

    // reset with every requester asking: nothing may be accepted
    for (int i = 0; i < NUM_REQ; i++) rand_req(i);
    @(negedge clk);
    @(negedge clk);
    next_cycle();
    rst = 1'b0;
    req_valid = '0;

    // T1: single subtract wrapping below zero
    set_req(0, 1'b1, OP_SUB, 3, 5);
    @(negedge clk);
    check("t1_ready", 0, 32'(t_ready[0]), 32'h1);
    next_cycle();
    req_valid[0] = 1'b0;
    idle(4);
    @(negedge clk);
    for (int k = 0; k < NLAT; k++) begin
      check("t1_busy", k, 32'(t_busy[k]), 32'(0));
      check("t1_rsp_id", k, 32'(t_rsp_id[k]), 32'(0));
      check("t1_rsp_data", k, 32'(t_rsp_data[k]), 32'd12287);
    end

    // T2: all four from reset, served 0,1,2,3
    next_cycle();
    rst = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, OP_ADD, i, 10);
    next_cycle();
    rst = 1'b0;
    for (int n = 0; n < NUM_REQ; n++) begin
      @(negedge clk);
      check("t2_grant", 0, 32'(t_ready[0]), 32'(1) << n);
      next_cycle();
      req_valid[n] = 1'b0;
    end
    idle(5);
    @(negedge clk);
    for (int k = 0; k < NLAT; k++) check("t2_last_data", k, 32'(t_rsp_data[k]), 32'd13);
    next_cycle();

    // T3: two continuous requesters alternate
    rand_req(1);
    rand_req(3);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      check("t3_grant", 0, 32'(t_ready[0]), (n % 2 == 0) ? 32'h2 : 32'h8);
      next_cycle();
      rand_req((n % 2 == 0) ? 1 : 3);
    end
    req_valid = '0;
    idle(5);

    // T4: hold rises together with the request
    hold = 1'b1;
    rand_req(2);
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      check("t4_ready_hold", 0, 32'(t_ready[0]), 32'(0));
      check("t4_dp_valid_hold", 0, 32'(t_dp_valid[0]), 32'(0));
      next_cycle();
    end
    hold = 1'b0;
    @(negedge clk);
    check("t4_ready_release", 0, 32'(t_ready[0]), 32'h4);
    check("t4_dp_valid_release", 0, 32'(t_dp_valid[0]), 32'(1));
    next_cycle();
    req_valid[2] = 1'b0;
    idle(5);

    // T5: reset while two ops are in flight
    rand_req(0);
    rand_req(1);
    @(negedge clk);
    check("t5_first", 0, 32'(t_ready[0]), 32'h1);
    next_cycle();
    req_valid[0] = 1'b0;
    @(negedge clk);
    check("t5_second", 0, 32'(t_ready[0]), 32'h2);
    next_cycle();
    req_valid[1] = 1'b0;
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    for (int k = 0; k < NLAT; k++) check("t5_busy_rst", k, 32'(t_busy[k]), 32'(0));
    next_cycle();
    rst = 1'b0;
    rand_req(0);
    rand_req(2);
    @(negedge clk);
    check("t5_grant_after_rst", 0, 32'(t_ready[0]), 32'h1);
    next_cycle();
    req_valid[0] = 1'b0;
    next_cycle();
    req_valid[2] = 1'b0;
    idle(6);

    // T6: random traffic with occasional hold
    for (int c = 0; c < 10000; c++) begin
      hold = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < NUM_REQ; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) rand_req(i);
      @(negedge clk);
      f   = m_fire;
      fid = m_id;
      next_cycle();
      if (f) req_valid[fid] = 1'b0;
    end
    hold = 1'b0;
    req_valid = '0;
    idle(8);
    for (int k = 0; k < NLAT; k++) check("t6_drained_busy", k, 32'(t_busy[k]), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
